tiny_dnn_agu: RTL and testbench

//  Parametrised convolution loop-nest sequencer / address generator for the tiny_dnn PE array.

---
 rtl/tiny_dnn_agu_pkg.sv | 44 ++++
 rtl/tiny_dnn_agu_cnt.sv | 35 +++
 rtl/tiny_dnn_agu.sv | 156 +++++++++++++++
 tb/tb_tiny_dnn_agu.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_dnn_agu_pkg.sv
// Shared types and helpers for the tiny_dnn convolution address generator.
// Optional stride support is controlled by TINY_DNN_AGU_STRIDE_EN in the top.
package tiny_dnn_agu_pkg;

    localparam int DEF_CW  = 4;
    localparam int DEF_SW  = 5;
    localparam int DEF_IAW = 12;
    localparam int DEF_WAW = 10;
    localparam int DEF_PW  = 10;
    localparam int CLIP_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        KINIT,
        EXEC,
        KFIN,
        WAIT,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic [CLIP_W-1:0] s;
        logic [CLIP_W-1:0] e;
    } clip_t;

    // Filter-tap range for one axis. Backprop clips taps that fall outside the input plane.
    function automatic clip_t clip_bounds(input logic [CLIP_W-1:0] o,
                                          input logic [CLIP_W-1:0] k,
                                          input logic [CLIP_W-1:0] i,
                                          input logic              mode);
        clip_t             r;
        logic [CLIP_W-1:0] org;
        org = o - k;
        r.s = '0;
        r.e = k;
        if (mode) begin
            if (org[CLIP_W-1]) r.s = -org;
            if (o > i)         r.e = i - org;
        end
        return r;
    endfunction

endpackage

// File: rtl/tiny_dnn_agu_cnt.sv
// Loop counter: loads i_ini on i_start, steps toward i_fin on i_en and wraps to i_ini.
// o_next is the value the counter takes at the next clock edge.
module tiny_dnn_agu_cnt
    import tiny_dnn_agu_pkg::*;
#(
    parameter int W = DEF_SW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_ini,
    input  logic [W-1:0] i_fin,
    input  logic         i_start,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_last,
    output logic [W-1:0] o_next
);

    logic [W-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == i_fin);

    always_comb begin
        o_next = r_cnt;
        if (i_start)   o_next = i_ini;
        else if (i_en) o_next = o_last ? i_ini : r_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= o_next;
    end

endmodule

// File: rtl/tiny_dnn_agu.sv
// Convolution loop-nest sequencer / SRAM address generator (forward and backprop).
// Define TINY_DNN_AGU_STRIDE_EN to add the stride port for forward mode.
module tiny_dnn_agu
    import tiny_dnn_agu_pkg::*;
#(
    parameter int CW  = DEF_CW,
    parameter int SW  = DEF_SW,
    parameter int IAW = DEF_IAW,
    parameter int WAW = DEF_WAW,
    parameter int PW  = DEF_PW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           backprop,
    input  logic           s_init,
    input  logic           out_busy,
    input  logic           outrf,
    input  logic           ex_stall,
    input  logic [CW-1:0]  dd,
    input  logic [CW-1:0]  id,
    input  logic [CW-1:0]  od,
    input  logic [SW-1:0]  ih,
    input  logic [SW-1:0]  iw,
    input  logic [SW-1:0]  oh,
    input  logic [SW-1:0]  ow,
    input  logic [SW-1:0]  kh,
    input  logic [SW-1:0]  kw,
    input  logic [PW-1:0]  is,
    input  logic [PW-1:0]  os,
    input  logic [PW-1:0]  fs,
    input  logic [PW-1:0]  ks,
`ifdef TINY_DNN_AGU_STRIDE_EN
    input  logic [1:0]     stride,
`endif
    output logic           s_fin,
    output logic           k_init,
    output logic           k_fin,
    output logic           exec,
    output logic [IAW-1:0] ia,
    output logic [WAW-1:0] wa,
    output state_t         dbg_state
);

    state_t         r_state, w_state_nx;
    logic           r_bp;
    logic [IAW-1:0] r_ia, w_ia_nx;
    logic [WAW-1:0] r_wa, w_wa_nx;
    logic [IAW-1:0] w_row, w_col, w_org_y, w_org_x;
    logic           w_run_start, w_kinit, w_kfin, w_step;
    logic           w_last_elem, w_last_kern;
    clip_t          w_clip_y, w_clip_x;

    logic [CW-1:0]  w_dc, w_dc_nx, w_ic, w_ic_nx;
    logic [SW-1:0]  w_oy, w_oy_nx, w_ox, w_ox_nx;
    logic [SW-1:0]  w_fy, w_fy_nx, w_fx, w_fx_nx;
    logic           w_dc_last, w_oy_last, w_ox_last, w_ic_last, w_fy_last, w_fx_last;
    logic           w_unused;

    assign w_run_start = (r_state == IDLE) && s_init;
    assign w_kinit     = (r_state == KINIT);
    assign w_kfin      = (r_state == KFIN);
    assign w_step      = (r_state == EXEC) && !ex_stall;
    assign w_last_elem = w_ic_last && w_fy_last && w_fx_last;
    assign w_last_kern = w_dc_last && w_oy_last && w_ox_last;

    assign w_clip_y = clip_bounds(CLIP_W'(w_oy), CLIP_W'(kh), CLIP_W'(ih), r_bp);
    assign w_clip_x = clip_bounds(CLIP_W'(w_ox), CLIP_W'(kw), CLIP_W'(iw), r_bp);

    // Outer loops: dc -> oy -> ox, stepped once per finished kernel.
    tiny_dnn_agu_cnt #(.W(CW)) u_dc (.clk(clk), .rst(rst), .i_ini('0), .i_fin(dd),
        .i_start(w_run_start), .i_en(w_kfin && w_oy_last && w_ox_last),
        .o_cnt(w_dc), .o_last(w_dc_last), .o_next(w_dc_nx));
    tiny_dnn_agu_cnt #(.W(SW)) u_oy (.clk(clk), .rst(rst), .i_ini('0), .i_fin(oh),
        .i_start(w_run_start), .i_en(w_kfin && w_ox_last),
        .o_cnt(w_oy), .o_last(w_oy_last), .o_next(w_oy_nx));
    tiny_dnn_agu_cnt #(.W(SW)) u_ox (.clk(clk), .rst(rst), .i_ini('0), .i_fin(ow),
        .i_start(w_run_start), .i_en(w_kfin),
        .o_cnt(w_ox), .o_last(w_ox_last), .o_next(w_ox_nx));

    // Element loops: ic -> fy -> fx, reloaded at every kernel start.
    tiny_dnn_agu_cnt #(.W(CW)) u_ic (.clk(clk), .rst(rst), .i_ini('0), .i_fin(id),
        .i_start(w_kinit), .i_en(w_step && w_fy_last && w_fx_last),
        .o_cnt(w_ic), .o_last(w_ic_last), .o_next(w_ic_nx));
    tiny_dnn_agu_cnt #(.W(SW)) u_fy (.clk(clk), .rst(rst), .i_ini(w_clip_y.s[SW-1:0]),
        .i_fin(w_clip_y.e[SW-1:0]), .i_start(w_kinit), .i_en(w_step && w_fx_last),
        .o_cnt(w_fy), .o_last(w_fy_last), .o_next(w_fy_nx));
    tiny_dnn_agu_cnt #(.W(SW)) u_fx (.clk(clk), .rst(rst), .i_ini(w_clip_x.s[SW-1:0]),
        .i_fin(w_clip_x.e[SW-1:0]), .i_start(w_kinit), .i_en(w_step),
        .o_cnt(w_fx), .o_last(w_fx_last), .o_next(w_fx_nx));

`ifdef TINY_DNN_AGU_STRIDE_EN
    logic [1:0] r_stride;
    assign w_org_y = IAW'(w_oy) * IAW'({1'b0, r_stride} + 3'd1);
    assign w_org_x = IAW'(w_ox) * IAW'({1'b0, r_stride} + 3'd1);
`else
    assign w_org_y = IAW'(w_oy);
    assign w_org_x = IAW'(w_ox);
`endif

    // Addresses are built from the counters' next values so they register alongside exec.
    assign w_row   = r_bp ? IAW'(w_oy) + IAW'(w_fy_nx) - IAW'(kh) : w_org_y + IAW'(w_fy_nx);
    assign w_col   = r_bp ? IAW'(w_ox) + IAW'(w_fx_nx) - IAW'(kw) : w_org_x + IAW'(w_fx_nx);
    assign w_ia_nx = IAW'(w_dc) * IAW'(is) + IAW'(w_ic_nx) * IAW'(is)
                   + w_row * (IAW'(iw) + 1'b1) + w_col;
    assign w_wa_nx = WAW'(w_ic_nx) * (WAW'(ks) + 1'b1) + WAW'(w_fy_nx) * (WAW'(kw) + 1'b1)
                   + WAW'(w_fx_nx);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (s_init) w_state_nx = KINIT;
            KINIT:   w_state_nx = EXEC;
            EXEC:    if (w_step && w_last_elem) w_state_nx = KFIN;
            KFIN:    w_state_nx = w_last_kern ? DRAIN : WAIT;
            WAIT:    if (!out_busy) w_state_nx = KINIT;
            DRAIN:   if (outrf) w_state_nx = FIN;
            FIN:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_bp    <= 1'b0;
            r_ia    <= '0;
            r_wa    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_run_start) r_bp <= backprop;
            if (w_state_nx == EXEC) begin
                r_ia <= w_ia_nx;
                r_wa <= w_wa_nx;
            end
        end
    end

`ifdef TINY_DNN_AGU_STRIDE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_stride <= 2'd0;
        else if (w_run_start) r_stride <= stride;
    end
`endif

    assign s_fin     = (r_state == FIN);
    assign k_init    = (r_state == KINIT);
    assign k_fin     = (r_state == KFIN);
    assign exec      = (r_state == EXEC);
    assign ia        = r_ia;
    assign wa        = r_wa;
    assign dbg_state = r_state;

    assign w_unused = ^{od, os, fs, w_clip_y, w_clip_x, w_dc_nx, w_oy_nx, w_ox_nx,
                        w_ic, w_fy, w_fx};

endmodule

// File: tb/tb_tiny_dnn_agu.sv
// Directed bench for tiny_dnn_agu: table of run configurations plus stall, backpressure,
// drain, stride and mid-run reset sequences.
module tb_tiny_dnn_agu;
    import tiny_dnn_agu_pkg::*;

    localparam int CW  = 4;
    localparam int SW  = 5;
    localparam int IAW = 12;
    localparam int WAW = 10;
    localparam int PW  = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           backprop = 1'b0, s_init = 1'b0, out_busy = 1'b0, outrf = 1'b1, ex_stall = 1'b0;
    logic [CW-1:0]  dd = '0, id = '0, od = '0;
    logic [SW-1:0]  ih = '0, iw = '0, oh = '0, ow = '0, kh = '0, kw = '0;
    logic [PW-1:0]  is = '0, os = '0, fs = '0, ks = '0;
`ifdef TINY_DNN_AGU_STRIDE_EN
    logic [1:0]     stride = 2'd0;
`endif
    logic           s_fin, k_init, k_fin, exec;
    logic [IAW-1:0] ia;
    logic [WAW-1:0] wa;
    state_t         dbg_state;

    tiny_dnn_agu #(.CW(CW), .SW(SW), .IAW(IAW), .WAW(WAW), .PW(PW)) dut (
        .clk(clk), .rst(rst), .backprop(backprop), .s_init(s_init), .out_busy(out_busy),
        .outrf(outrf), .ex_stall(ex_stall), .dd(dd), .id(id), .od(od),
        .ih(ih), .iw(iw), .oh(oh), .ow(ow), .kh(kh), .kw(kw),
        .is(is), .os(os), .fs(fs), .ks(ks),
`ifdef TINY_DNN_AGU_STRIDE_EN
        .stride(stride),
`endif
        .s_fin(s_fin), .k_init(k_init), .k_fin(k_fin), .exec(exec),
        .ia(ia), .wa(wa), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                bp;
        logic [CW-1:0]       dd, id;
        logic [SW-1:0]       ih, iw, oh, ow, kh, kw;
        logic [PW-1:0]       is, ks;
        int                  n_kern, n_exec, n_first;
        logic [3:0][IAW-1:0] f_ia;
        logic [3:0][WAW-1:0] f_wa;
        int                  last_ia, last_wa, k_idx, k_n;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int kinit_q[$], kfin_q[$], sfin_q[$];
    int ia_q[$], wa_q[$], kern_q[$];
    int st_ia_q[$], st_wa_q[$];
    int rise_cyc;
    int extra_after;
    bit run_done;
    logic [IAW-1:0] exp_q[$];
    vec_t vt[4];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit bp, input int d_dd, input int d_id, input int d_ih,
                                input int d_iw, input int d_oh, input int d_ow, input int d_kh,
                                input int d_kw, input int d_is, input int d_ks,
                                input int nk, input int ne, input int nf,
                                input int a0, input int a1, input int a2, input int a3,
                                input int w0, input int w1, input int w2, input int w3,
                                input int lia, input int lwa, input int kidx, input int kn);
        vec_t v;
        v.bp = bp;
        v.dd = CW'(d_dd); v.id = CW'(d_id);
        v.ih = SW'(d_ih); v.iw = SW'(d_iw); v.oh = SW'(d_oh); v.ow = SW'(d_ow);
        v.kh = SW'(d_kh); v.kw = SW'(d_kw);
        v.is = PW'(d_is); v.ks = PW'(d_ks);
        v.n_kern = nk; v.n_exec = ne; v.n_first = nf;
        v.f_ia[0] = IAW'(a0); v.f_ia[1] = IAW'(a1); v.f_ia[2] = IAW'(a2); v.f_ia[3] = IAW'(a3);
        v.f_wa[0] = WAW'(w0); v.f_wa[1] = WAW'(w1); v.f_wa[2] = WAW'(w2); v.f_wa[3] = WAW'(w3);
        v.last_ia = lia; v.last_wa = lwa; v.k_idx = kidx; v.k_n = kn;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        backprop = v.bp;
        dd = v.dd; id = v.id; od = '0;
        ih = v.ih; iw = v.iw; oh = v.oh; ow = v.ow; kh = v.kh; kw = v.kw;
        is = v.is; ks = v.ks; os = '0; fs = '0;
    endtask

    // One full run from s_init to s_fin; records pulses and every non-stalled exec beat.
    task automatic run(input int n_kern, input int stall_at, input int stall_len,
                       input int busy_len, input int outrf_dly, input bit reinit);
        int  stall_rem;
        int  busy_rem;
        int  drain_rem;
        bit  done;
        stall_rem = stall_len; busy_rem = 0; drain_rem = -1; done = 1'b0; rise_cyc = -1;
        kinit_q.delete(); kfin_q.delete(); sfin_q.delete();
        ia_q.delete(); wa_q.delete(); kern_q.delete(); st_ia_q.delete(); st_wa_q.delete();
        @(negedge clk);
        s_init = 1'b1;
        outrf  = (outrf_dly == 0);
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            cyc++;
            s_init = 1'b0;
            if (k_init) kinit_q.push_back(cyc);
            if (k_fin)  kfin_q.push_back(cyc);
            if (s_fin) begin
                sfin_q.push_back(cyc);
                done = 1'b1;
            end
            if (exec && ia_q.size() == stall_at && stall_rem > 0) begin
                ex_stall = 1'b1;
                stall_rem--;
                st_ia_q.push_back(int'(ia));
                st_wa_q.push_back(int'(wa));
            end else begin
                ex_stall = 1'b0;
                if (exec) begin
                    ia_q.push_back(int'(ia));
                    wa_q.push_back(int'(wa));
                    kern_q.push_back(kinit_q.size() - 1);
                end
            end
            if (k_fin && kfin_q.size() == 1 && busy_len > 0) busy_rem = busy_len;
            out_busy = (busy_rem > 0);
            if (busy_rem > 0) busy_rem--;
            if (k_fin && kfin_q.size() == n_kern) drain_rem = outrf_dly;
            if (drain_rem > 0) begin
                outrf = 1'b0;
                drain_rem--;
                if (reinit && drain_rem == 5) s_init = 1'b1;
            end else if (drain_rem == 0 && !outrf) begin
                outrf = 1'b1;
                rise_cyc = cyc;
            end
        end
        run_done = done;
        ex_stall = 1'b0; out_busy = 1'b0; outrf = 1'b1; s_init = 1'b0;
        extra_after = 0;
        repeat (4) begin
            @(negedge clk);
            cyc++;
            if (k_init || k_fin || exec || s_fin) extra_after++;
        end
    endtask

    function automatic int kern_count(input int k);
        int n;
        n = 0;
        foreach (kern_q[j]) if (kern_q[j] == k) n++;
        return n;
    endfunction

    initial begin
        vt[0] = mk(0, 0, 0, 2, 2, 1, 1, 1, 1, 8, 3, 4, 16, 4, 0, 1, 3, 4, 0, 1, 2, 3, 8, 3, 3, 4);
        vt[1] = mk(1, 0, 0, 1, 1, 2, 2, 1, 1, 3, 3, 9, 16, 1, 0, 0, 0, 0, 3, 0, 0, 0, 3, 0, 4, 4);
        vt[2] = mk(0, 1, 1, 0, 3, 0, 0, 0, 1, 4, 1, 2, 8, 4, 0, 1, 4, 5, 0, 1, 2, 3, 9, 3, 1, 4);
        vt[3] = mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 2, 0, 2, 4, 2, 0, 2, 0, 0, 0, 1, 0, 0, 3, 1, 1, 2);

        #12;
        chk("rst_s_fin", s_fin, 0);
        chk("rst_k_init", k_init, 0);
        chk("rst_k_fin", k_fin, 0);
        chk("rst_exec", exec, 0);
        chk("rst_ia", ia, 0);
        chk("rst_wa", wa, 0);
        chk("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            apply(vt[i]);
            run(vt[i].n_kern, -1, 0, 0, 0, 1'b0);
            chk($sformatf("v%0d_done", i), run_done, 1);
            chk($sformatf("v%0d_kinit_n", i), kinit_q.size(), vt[i].n_kern);
            chk($sformatf("v%0d_kfin_n", i), kfin_q.size(), vt[i].n_kern);
            chk($sformatf("v%0d_sfin_n", i), sfin_q.size(), 1);
            chk($sformatf("v%0d_exec_n", i), ia_q.size(), vt[i].n_exec);
            chk($sformatf("v%0d_first_n", i), kern_count(0), vt[i].n_first);
            chk($sformatf("v%0d_kern%0d_n", i, vt[i].k_idx), kern_count(vt[i].k_idx), vt[i].k_n);
            exp_q.delete();
            for (int j = 0; j < vt[i].n_first; j++) exp_q.push_back(vt[i].f_ia[j]);
            for (int j = 0; j < vt[i].n_first; j++) begin
                chk($sformatf("v%0d_ia%0d", i, j), (j < ia_q.size()) ? ia_q[j] : -1,
                    int'(exp_q.pop_front()));
                chk($sformatf("v%0d_wa%0d", i, j), (j < wa_q.size()) ? wa_q[j] : -1,
                    int'(vt[i].f_wa[j]));
            end
            chk($sformatf("v%0d_last_ia", i), (ia_q.size() > 0) ? ia_q[$] : -1, vt[i].last_ia);
            chk($sformatf("v%0d_last_wa", i), (wa_q.size() > 0) ? wa_q[$] : -1, vt[i].last_wa);
            chk($sformatf("v%0d_wait_gap", i),
                (kinit_q.size() > 1 && kfin_q.size() > 0) ? kinit_q[1] - kfin_q[0] : -1, 2);
            chk($sformatf("v%0d_drain_gap", i),
                (sfin_q.size() > 0 && kfin_q.size() > 0) ? sfin_q[0] - kfin_q[$] : -1, 2);
            chk($sformatf("v%0d_idle_after", i), extra_after, 0);
        end

        // Stall on the second beat of the first kernel for three cycles.
        apply(vt[0]);
        run(4, 1, 3, 0, 0, 1'b0);
        chk("stall_done", run_done, 1);
        chk("stall_hold_n", st_ia_q.size(), 3);
        foreach (st_ia_q[j]) begin
            chk($sformatf("stall_ia%0d", j), st_ia_q[j], 1);
            chk($sformatf("stall_wa%0d", j), st_wa_q[j], 1);
        end
        chk("stall_k0_n", kern_count(0), 4);
        chk("stall_ia2", (ia_q.size() > 2) ? ia_q[2] : -1, 3);
        chk("stall_exec_n", ia_q.size(), 16);
        chk("stall_kfin_delay",
            (kfin_q.size() > 0 && kinit_q.size() > 0) ? kfin_q[0] - kinit_q[0] : -1, 8);

        // out_busy raised with the first k_fin and held five cycles.
        apply(vt[0]);
        run(4, -1, 0, 5, 0, 1'b0);
        chk("busy_done", run_done, 1);
        chk("busy_gap", (kinit_q.size() > 1 && kfin_q.size() > 0) ? kinit_q[1] - kfin_q[0] : -1, 6);
        chk("busy_kinit_n", kinit_q.size(), 4);

        // outrf held low through DRAIN, with a stray s_init in the middle.
        apply(vt[0]);
        run(4, -1, 0, 0, 10, 1'b1);
        chk("drain_done", run_done, 1);
        chk("drain_sfin_n", sfin_q.size(), 1);
        chk("drain_gap", (sfin_q.size() > 0 && kfin_q.size() > 0) ? sfin_q[0] - kfin_q[$] : -1, 11);
        chk("drain_rise", (sfin_q.size() > 0) ? sfin_q[0] - rise_cyc : -1, 1);
        chk("drain_kinit_n", kinit_q.size(), 4);
        chk("drain_idle_after", extra_after, 0);

`ifdef TINY_DNN_AGU_STRIDE_EN
        apply(mk(0, 0, 0, 0, 3, 0, 1, 0, 0, 4, 0, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 1));
        stride = 2'd1;
        run(2, -1, 0, 0, 0, 1'b0);
        chk("stride_done", run_done, 1);
        chk("stride_ia0", (ia_q.size() > 0) ? ia_q[0] : -1, 0);
        chk("stride_ia1", (ia_q.size() > 1) ? ia_q[1] : -1, 2);
        stride = 2'd0;
`endif

        // Asynchronous reset while a kernel is executing.
        begin
            bit seen;
            int n_act;
            seen = 1'b0;
            apply(vt[0]);
            @(negedge clk);
            s_init = 1'b1;
            @(negedge clk);
            s_init = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk);
                if (exec && ia == 3) seen = 1'b1;
            end
            chk("rstmid_reached", seen, 1);
            #2;
            rst = 1'b1;
            #1;
            chk("rstmid_exec", exec, 0);
            chk("rstmid_ia", ia, 0);
            chk("rstmid_wa", wa, 0);
            chk("rstmid_kinit", k_init, 0);
            chk("rstmid_kfin", k_fin, 0);
            chk("rstmid_sfin", s_fin, 0);
            @(negedge clk);
            rst = 1'b0;
            n_act = 0;
            repeat (6) begin
                @(negedge clk);
                if (k_init || k_fin || exec || s_fin) n_act++;
            end
            chk("rstmid_quiet", n_act, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
